sum16_serial_ctrl: RTL

Nibble-serial 16-bit add/subtract controller. It sequences one shared 4-bit ripple adder over four clock cycles to produce a 16-bit sum or difference, with carry-out and signed overflow. It sits between the lab's operand/switch registers and the display path, and trades latency for reuse of the existing 4-bit adder datapath. A start/busy/done handshake frames each operation.

---
 rtl/sum16_serial_ctrl_pkg.sv | 18 +
 rtl/sum16_serial_ctrl_if.sv | 29 ++
 rtl/sum16_serial_ctrl_nib_add4.sv | 24 ++
 rtl/sum16_serial_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/sum16_serial_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// FSM state encodings, default nibble count and counter sizing helper.
package sum16_serial_ctrl_pkg;

  localparam int DEF_N_NIB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble index counter width; never narrower than one bit.
  function automatic int idx_width(input int n_nib);
    return (n_nib > 1) ? $clog2(n_nib) : 1;
  endfunction

endpackage

// File: rtl/sum16_serial_ctrl_if.sv
// Operand/result handshake bundle between the operand registers (master)
// and the serial add/subtract controller (slave).
interface sum16_serial_ctrl_if #(
  parameter int N_NIB = 4
) ();

  localparam int W = 4 * N_NIB;

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/sum16_serial_ctrl_nib_add4.sv
// Combinational 4-bit ripple adder with carry-in; the shared datapath
// element that the serial controller reuses once per nibble.
module nib_add4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);

  logic w_c;

  // Bit-by-bit ripple, carry flows from bit 0 upward.
  always_comb begin
    w_c = i_ci;
    o_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/sum16_serial_ctrl.sv
// Nibble-serial W-bit add/subtract controller. One shared 4-bit adder is
// stepped over N_NIB cycles; result, carry-out and signed overflow are
// registered on completion and held until the next one.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; operands captured on the accepting edge
//   ST_RUN  | one nibble per cycle through the shared adder (busy = 1)
//   ST_DONE | outputs just updated, one-cycle done pulse
//   2'd3    | unused, recovers to ST_IDLE
//
// N_NIB is expected to be at least 2.
module sum16_serial_ctrl
  import sum16_serial_ctrl_pkg::*;
#(
  parameter int N_NIB = DEF_N_NIB
) (
  input logic           clk,
  input logic           rst_n,
  sum16_serial_ctrl_if.slave bus
);

  localparam int W     = 4 * N_NIB;
  localparam int IDX_W = idx_width(N_NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

  state_t           r_state;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_acc;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_a_msb;
  logic             r_beff_msb;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_ovf;

  logic [W-1:0]     w_b_eff;
  logic [3:0]       w_s;
  logic             w_co;
  logic [W-1:0]     w_acc_next;

  assign w_b_eff    = bus.op_sub ? ~bus.b : bus.b;
  assign w_acc_next = {w_s, r_acc[W-1:4]};

  nib_add4 u_nib_add4 (
    .i_a  (r_a_sh[3:0]),
    .i_b  (r_b_sh[3:0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // Sequencer: operand capture, per-nibble shift/accumulate, result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_a_msb    <= 1'b0;
      r_beff_msb <= 1'b0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a_sh     <= bus.a;
            r_b_sh     <= w_b_eff;
            r_carry    <= bus.op_sub;
            r_idx      <= '0;
            r_a_msb    <= bus.a[W-1];
            r_beff_msb <= w_b_eff[W-1];
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_a_sh  <= {4'b0000, r_a_sh[W-1:4]};
          r_b_sh  <= {4'b0000, r_b_sh[W-1:4]};
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_result <= w_acc_next;
            r_cout   <= w_co;
            r_ovf    <= (r_a_msb == r_beff_msb) && (w_s[3] != r_a_msb);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state == ST_RUN);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

endmodule
